uart_tx_fifo: RTL

UART transmitter with a small input FIFO, the transmit-side counterpart of the team's UART receiver. It runs entirely on `baud_clk`, where one clock period equals one bit time. It serialises 8N1 frames, or 8E1/8O1 frames when parity is compiled in, onto `tx`. Bytes are accepted through a valid/ready handshake and buffered so frames go out back-to-back without idle gaps.

---
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1/8O1 with UART_TX_PARITY_EN defined) fed by a small FIFO.
// One baud_clk period is one bit time; frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int DEPTH      = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                     baud_clk,
  input  logic                     rst,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  state_t        state_r, state_s;
  logic [7:0]    shift_r, shift_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic          stop_cnt_r, stop_cnt_s;
  logic          tx_r, tx_s;
  logic          frame_done_r, frame_done_s;
  logic          push_s, pop_s;
  logic [7:0]    head_s;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD_BIT = 1'(PARITY_ODD);
  logic par_r, par_s;

  function automatic logic calc_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  logic unused_cfg_s;
  assign unused_cfg_s = 1'(PARITY_ODD);
`endif

  assign push_s     = tx_valid && tx_ready;
  assign head_s     = mem_r[rd_ptr_r];
  assign tx_ready   = (count_r != FULL_CNT);
  assign tx         = tx_r;
  assign busy       = (state_r != IDLE);
  assign fifo_count = count_r;
  assign frame_done = frame_done_r;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge baud_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer next-state and line value
  always_comb begin
    state_s      = state_r;
    tx_s         = tx_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    stop_cnt_s   = stop_cnt_r;
    frame_done_s = 1'b0;
    pop_s        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_s        = par_r;
`endif
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (count_r != CNT_ZERO) begin
          pop_s   = 1'b1;
          shift_s = head_s;
`ifdef UART_TX_PARITY_EN
          par_s   = calc_parity(head_s, ODD_BIT);
`endif
          tx_s    = 1'b0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_s      = shift_r[0];
        bit_cnt_s = 3'd0;
        state_s   = DATA;
      end
      DATA: begin
        if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          tx_s       = par_r;
          state_s    = PARITY;
`else
          tx_s       = 1'b1;
          stop_cnt_s = 1'b0;
          state_s    = STOP;
`endif
        end else begin
          bit_cnt_s = bit_cnt_r + 3'd1;
          tx_s      = shift_r[bit_cnt_r + 3'd1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_s       = 1'b1;
        stop_cnt_s = 1'b0;
        state_s    = STOP;
      end
`endif
      STOP: begin
        tx_s = 1'b1;
        if (stop_cnt_r == STOP_LAST) begin
          frame_done_s = 1'b1;
          // Reload straight from the FIFO so the next start bit follows with no idle gap
          if (count_r != CNT_ZERO) begin
            pop_s   = 1'b1;
            shift_s = head_s;
`ifdef UART_TX_PARITY_EN
            par_s   = calc_parity(head_s, ODD_BIT);
`endif
            tx_s    = 1'b0;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          stop_cnt_s = stop_cnt_r + 1'b1;
        end
      end
      default: begin
        tx_s    = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Frame sequencer registers
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      tx_r         <= 1'b1;
      shift_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
      stop_cnt_r   <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      tx_r         <= tx_s;
      shift_r      <= shift_s;
      bit_cnt_r    <= bit_cnt_s;
      stop_cnt_r   <= stop_cnt_s;
      frame_done_r <= frame_done_s;
`ifdef UART_TX_PARITY_EN
      par_r        <= par_s;
`endif
    end
  end

endmodule
